// File: rtl/rf_wport_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_wport_arb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // One buffered long-unit result: destination register and write data.
  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
  } wbuf_entry_t;

endpackage

// File: rtl/rf_wbuf_fifo.sv
// Small FIFO holding long-unit results until a free WB slot drains them.
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_wbuf_fifo
  import rf_wport_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  wbuf_entry_t push_data,
  input  logic        pop,
  output wbuf_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wbuf_entry_t     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wport_arb.sv
// Write-port arbiter for the general register file. WB always wins the port;
// buffered long-unit results drain into idle WB slots. A pending-destination
// scoreboard drives the ID read-hazard stall.
// Optional WB-bubble request on long-unit starvation: define RF_ARB_STARVE_EN.
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_a3,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              iss_en,
  input  logic [REG_W-1:0]  iss_a3,
  input  logic              lu_vld,
  input  logic [REG_W-1:0]  lu_a3,
  input  logic [DATA_W-1:0] lu_wd,
  output logic              lu_rdy,
  input  logic [REG_W-1:0]  chk_a1,
  input  logic [REG_W-1:0]  chk_a2,
  output logic              hz_stall,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  output logic              wb_hold
);

  logic        wbe;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  wbuf_entry_t fifo_head;
  wbuf_entry_t lu_entry;
  logic [31:0] sb;
  logic [31:0] sb_next;

  // Writes to $0 are dropped and leave the slot free for the buffer.
  assign wbe       = wb_we && (wb_a3 != REG_ZERO);
  assign lu_rdy    = !fifo_full;
  assign fifo_pop  = !wbe && !fifo_empty;
  // Results for $0 are accepted but never stored.
  assign fifo_push = lu_vld && lu_rdy && (lu_a3 != REG_ZERO);
  assign lu_entry  = '{a3: lu_a3, wd: lu_wd};

  rf_wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (lu_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Port mux: WB first, then the buffer head, otherwise an idle port.
  always_comb begin
    rf_we = 1'b0;
    rf_a3 = REG_ZERO;
    rf_wd = '0;
    if (wbe) begin
      rf_we = 1'b1;
      rf_a3 = wb_a3;
      rf_wd = wb_wd;
    end else if (!fifo_empty) begin
      rf_we = 1'b1;
      rf_a3 = fifo_head.a3;
      rf_wd = fifo_head.wd;
    end
  end

  // Scoreboard update: a pop retires its register, a new issue re-arms it (issue wins).
  always_comb begin
    sb_next = sb;
    if (fifo_pop) sb_next[fifo_head.a3] = 1'b0;
    if (iss_en && (iss_a3 != REG_ZERO)) sb_next[iss_a3] = 1'b1;
  end

  // Scoreboard register; bit 0 is pinned low so $0 never stalls.
  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= {sb_next[31:1], 1'b0};
  end

  // Hazard sees the registered scoreboard only; a pop this cycle still stalls.
  assign hz_stall = ((chk_a1 != REG_ZERO) && sb[chk_a1]) ||
                    ((chk_a2 != REG_ZERO) && sb[chk_a2]);

`ifdef RF_ARB_STARVE_EN
  localparam int SW = ($clog2(STARVE_MAX + 1) > 4) ? $clog2(STARVE_MAX + 1) : 4;

  logic [SW-1:0] starve_cnt;

  // Count cycles the buffer head waits behind WB; saturate, clear on any pop.
  always_ff @(posedge clk) begin
    if (rst)                                               starve_cnt <= '0;
    else if (fifo_pop)                                     starve_cnt <= '0;
    else if (!fifo_empty && wbe && (starve_cnt != '1))     starve_cnt <= starve_cnt + 1'b1;
  end

  assign wb_hold = (starve_cnt >= SW'(STARVE_MAX));
`else
  // Feature compiled out: the comparison is a constant false.
  assign wb_hold = (STARVE_MAX < 0);
`endif

endmodule
